// File: rtl/spi_slave_ram_if.sv
// Serial pins between an SPI master and the spi_slave_ram slave.
// Handshake: a transaction is framed by SS_n low; MOSI is sampled on every rising clk
// while framed; MISO carries read data and idles at 0.
interface spi_slave_ram_if;
    logic MOSI;
    logic MISO;
    logic SS_n;

    modport master (output MOSI, output SS_n, input MISO);
    modport slave  (input MOSI, input SS_n, output MISO);
endinterface

// File: rtl/spi_slave_ram.sv
// SPI slave front end with a 256 x 8 RAM: 10-bit frames carry a 2-bit command and an
// 8-bit payload; command 11 shifts the addressed byte back MSB-first on MISO.
module spi_slave_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_slave_ram_if.slave       spi,
    output logic [2:0]           dbg_state,
    output logic [9:0]           dbg_rx_data,
    output logic                 dbg_rx_valid,
    output logic                 dbg_tx_valid,
    output logic [ADDR_SIZE-1:0] dbg_addr_wr,
    output logic [ADDR_SIZE-1:0] dbg_addr_rd,
    output logic                 dbg_rd_addr_seen,
    output logic [7:0]           dbg_dout
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [3:0]           bit_cnt;
    logic [9:0]           rx_data;
    logic                 rx_valid;
    logic [9:0]           din;
    logic                 receiving;

    logic [7:0]           mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] addr_wr;
    logic [ADDR_SIZE-1:0] addr_rd;
    logic                 rd_addr_seen;
    logic [7:0]           dout;
    logic                 tx_valid;

    logic                 miso;
    logic [6:0]           tx_sh;
    logic [2:0]           tx_left;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (spi.SS_n) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = CHK_CMD;
                CHK_CMD: begin
                    if (!spi.MOSI)        state_d = WRITE;
                    else if (rd_addr_seen) state_d = READ_DATA;
                    else                   state_d = READ_ADD;
                end
                default: state_d = state_q;
            endcase
        end
    end

    assign receiving = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);

    // Bits past the tenth are dropped: the counter parks at 10 until the frame ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= 4'd0;
            rx_data  <= 10'd0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (spi.SS_n || !receiving) begin
                bit_cnt <= 4'd0;
            end else if (bit_cnt != 4'd10) begin
                rx_data  <= {rx_data[8:0], spi.MOSI};
                bit_cnt  <= bit_cnt + 4'd1;
                rx_valid <= (bit_cnt == 4'd9);
            end
        end
    end

    assign din = rx_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_wr      <= '0;
            addr_rd      <= '0;
            rd_addr_seen <= 1'b0;
            dout         <= 8'd0;
            tx_valid     <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            if (rx_valid) begin
                case (din[9:8])
                    2'b00: addr_wr <= din[7:0];
                    2'b10: begin
                        addr_rd      <= din[7:0];
                        rd_addr_seen <= 1'b1;
                    end
                    2'b11: begin
                        dout         <= mem[addr_rd];
                        tx_valid     <= 1'b1;
                        rd_addr_seen <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Storage is deliberately left out of reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (rx_valid && (din[9:8] == 2'b01)) mem[addr_wr] <= din[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso    <= 1'b0;
            tx_sh   <= 7'd0;
            tx_left <= 3'd0;
        end else if (spi.SS_n) begin
            miso    <= 1'b0;
            tx_left <= 3'd0;
        end else if (tx_valid && (state_q == READ_DATA)) begin
            miso    <= dout[7];
            tx_sh   <= dout[6:0];
            tx_left <= 3'd7;
        end else if (tx_left != 3'd0) begin
            miso    <= tx_sh[6];
            tx_sh   <= {tx_sh[5:0], 1'b0};
            tx_left <= tx_left - 3'd1;
        end else begin
            miso <= 1'b0;
        end
    end

    assign spi.MISO = miso;

    assign dbg_state        = state_q;
    assign dbg_rx_data      = rx_data;
    assign dbg_rx_valid     = rx_valid;
    assign dbg_tx_valid     = tx_valid;
    assign dbg_addr_wr      = addr_wr;
    assign dbg_addr_rd      = addr_rd;
    assign dbg_rd_addr_seen = rd_addr_seen;
    assign dbg_dout         = dout;

endmodule

// File: tb/tb_spi_slave_ram.sv
// Directed bench for spi_slave_ram: serial frames driven bit by bit, results checked
// against hand-computed values and bytes read back over MISO.
module tb_spi_slave_ram;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CHK_CMD   = 3'd1;
  localparam logic [2:0] S_WRITE     = 3'd2;
  localparam logic [2:0] S_READ_ADD  = 3'd3;
  localparam logic [2:0] S_READ_DATA = 3'd4;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  logic [9:0] dbg_rx_data;
  logic       dbg_rx_valid;
  logic       dbg_tx_valid;
  logic [7:0] dbg_addr_wr;
  logic [7:0] dbg_addr_rd;
  logic       dbg_rd_addr_seen;
  logic [7:0] dbg_dout;

  int checks   = 0;
  int failures = 0;
  int rx_pulses = 0;

  spi_slave_ram_if bus ();

  spi_slave_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .spi              (bus),
    .dbg_state        (dbg_state),
    .dbg_rx_data      (dbg_rx_data),
    .dbg_rx_valid     (dbg_rx_valid),
    .dbg_tx_valid     (dbg_tx_valid),
    .dbg_addr_wr      (dbg_addr_wr),
    .dbg_addr_rd      (dbg_addr_rd),
    .dbg_rd_addr_seen (dbg_rd_addr_seen),
    .dbg_dout         (dbg_dout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (dbg_rx_valid === 1'b1) rx_pulses++;

  // driver tasks
  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic sel);
    bus.SS_n = 1'b0;
    bus.MOSI = 1'b0;
    clk_step();
    bus.MOSI = sel;
    clk_step();
  endtask

  task automatic shift_bits(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) begin
      bus.MOSI = w[i];
      clk_step();
    end
  endtask

  task automatic end_frame();
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    clk_step();
  endtask

  task automatic write_byte(input logic [7:0] addr, input logic [7:0] data);
    start_frame(1'b0);
    shift_bits({2'b00, addr});
    clk_step();
    end_frame();
    start_frame(1'b0);
    shift_bits({2'b01, data});
    clk_step();
    end_frame();
  endtask

  task automatic read_back(input logic [7:0] addr, output logic [7:0] got);
    got = 8'd0;
    start_frame(1'b1);
    shift_bits({2'b10, addr});
    clk_step();
    end_frame();
    start_frame(1'b1);
    shift_bits(10'h300);
    clk_step();
    for (int i = 0; i < 8; i++) begin
      clk_step();
      got = {got[6:0], bus.MISO};
    end
    clk_step();
    end_frame();
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    repeat (5) clk_step();
    checks++; if (bus.MISO !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", bus.MISO); end
    checks++; if (dbg_addr_wr !== 8'h00) begin failures++; $display("FAIL reset_addr_wr got=%h exp=00", dbg_addr_wr); end
    checks++; if (dbg_addr_rd !== 8'h00) begin failures++; $display("FAIL reset_addr_rd got=%h exp=00", dbg_addr_rd); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    checks++; if (dbg_rd_addr_seen !== 1'b0) begin failures++; $display("FAIL reset_rd_addr_seen got=%b exp=0", dbg_rd_addr_seen); end
    rst_n = 1'b1;
    clk_step();
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL idle_hold got=%0d exp=%0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_write_addr();
    start_frame(1'b0);
    checks++; if (dbg_state !== S_WRITE) begin failures++; $display("FAIL wa_state got=%0d exp=%0d", dbg_state, S_WRITE); end
    shift_bits(10'b00_0011_1100);
    checks++; if (dbg_rx_valid !== 1'b1) begin failures++; $display("FAIL wa_rx_valid got=%b exp=1", dbg_rx_valid); end
    checks++; if (dbg_rx_data !== 10'h03C) begin failures++; $display("FAIL wa_rx_data got=%h exp=03c", dbg_rx_data); end
    clk_step();
    checks++; if (dbg_rx_valid !== 1'b0) begin failures++; $display("FAIL wa_rx_valid_pulse got=%b exp=0", dbg_rx_valid); end
    checks++; if (dbg_addr_wr !== 8'h3C) begin failures++; $display("FAIL wa_addr_wr got=%h exp=3c", dbg_addr_wr); end
    end_frame();
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL wa_idle got=%0d exp=%0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_write_data();
    start_frame(1'b0);
    shift_bits(10'b01_1010_0101);
    checks++; if (dbg_rx_data !== 10'h1A5) begin failures++; $display("FAIL wd_rx_data got=%h exp=1a5", dbg_rx_data); end
    clk_step();
    checks++; if (bus.MISO !== 1'b0) begin failures++; $display("FAIL wd_miso got=%b exp=0", bus.MISO); end
    end_frame();
  endtask

  task automatic test_read_addr();
    start_frame(1'b1);
    checks++; if (dbg_state !== S_READ_ADD) begin failures++; $display("FAIL ra_state got=%0d exp=%0d", dbg_state, S_READ_ADD); end
    shift_bits(10'b10_0011_1100);
    checks++; if (dbg_rx_data !== 10'h23C) begin failures++; $display("FAIL ra_rx_data got=%h exp=23c", dbg_rx_data); end
    clk_step();
    checks++; if (dbg_addr_rd !== 8'h3C) begin failures++; $display("FAIL ra_addr_rd got=%h exp=3c", dbg_addr_rd); end
    checks++; if (dbg_rd_addr_seen !== 1'b1) begin failures++; $display("FAIL ra_seen got=%b exp=1", dbg_rd_addr_seen); end
    end_frame();
  endtask

  task automatic test_read_data();
    logic [7:0] exp_byte;
    exp_byte = 8'hA5;
    start_frame(1'b1);
    checks++; if (dbg_state !== S_READ_DATA) begin failures++; $display("FAIL rd_state got=%0d exp=%0d", dbg_state, S_READ_DATA); end
    shift_bits(10'b11_0000_0000);
    checks++; if (dbg_rx_valid !== 1'b1) begin failures++; $display("FAIL rd_rx_valid got=%b exp=1", dbg_rx_valid); end
    clk_step();
    checks++; if (dbg_tx_valid !== 1'b1) begin failures++; $display("FAIL rd_tx_valid got=%b exp=1", dbg_tx_valid); end
    checks++; if (dbg_dout !== exp_byte) begin failures++; $display("FAIL rd_dout got=%h exp=%h", dbg_dout, exp_byte); end
    checks++; if (dbg_rd_addr_seen !== 1'b0) begin failures++; $display("FAIL rd_seen_clr got=%b exp=0", dbg_rd_addr_seen); end
    checks++; if (bus.MISO !== 1'b0) begin failures++; $display("FAIL rd_miso_pre got=%b exp=0", bus.MISO); end
    for (int i = 7; i >= 0; i--) begin
      clk_step();
      if (i == 7) begin
        checks++; if (dbg_tx_valid !== 1'b0) begin failures++; $display("FAIL rd_tx_pulse got=%b exp=0", dbg_tx_valid); end
      end
      checks++; if (bus.MISO !== exp_byte[i]) begin failures++; $display("FAIL rd_miso_bit%0d got=%b exp=%b", i, bus.MISO, exp_byte[i]); end
    end
    clk_step();
    checks++; if (bus.MISO !== 1'b0) begin failures++; $display("FAIL rd_miso_post got=%b exp=0", bus.MISO); end
    repeat (2) clk_step();
    checks++; if (bus.MISO !== 1'b0) begin failures++; $display("FAIL rd_miso_idle got=%b exp=0", bus.MISO); end
    end_frame();
  endtask

  task automatic test_abort();
    int         p0;
    logic [7:0] got;
    logic [5:0] partial;
    partial = 6'b01_1111;
    p0 = rx_pulses;
    start_frame(1'b0);
    for (int i = 5; i >= 0; i--) begin
      bus.MOSI = partial[i];
      clk_step();
    end
    end_frame();
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL ab_idle got=%0d exp=%0d", dbg_state, S_IDLE); end
    checks++; if (rx_pulses !== p0) begin failures++; $display("FAIL ab_no_rx_valid got=%0d exp=%0d", rx_pulses, p0); end
    checks++; if (dbg_addr_wr !== 8'h3C) begin failures++; $display("FAIL ab_addr_wr got=%h exp=3c", dbg_addr_wr); end
    read_back(8'h3C, got);
    checks++; if (got !== 8'hA5) begin failures++; $display("FAIL ab_mem_kept got=%h exp=a5", got); end
    checks++; if (rx_pulses !== p0 + 2) begin failures++; $display("FAIL ab_next_frames got=%0d exp=%0d", rx_pulses, p0 + 2); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    write_byte(8'hFF, 8'h5A);
    write_byte(8'h00, 8'hC3);
    write_byte(8'h3C, 8'h81);
    read_back(8'hFF, got);
    checks++; if (got !== 8'h5A) begin failures++; $display("FAIL b2b_ff got=%h exp=5a", got); end
    read_back(8'h00, got);
    checks++; if (got !== 8'hC3) begin failures++; $display("FAIL b2b_00 got=%h exp=c3", got); end
    read_back(8'h3C, got);
    checks++; if (got !== 8'h81) begin failures++; $display("FAIL b2b_3c got=%h exp=81", got); end
  endtask

  task automatic test_reset_keeps_mem();
    logic [7:0] got;
    rst_n = 1'b0;
    repeat (2) clk_step();
    rst_n = 1'b1;
    clk_step();
    read_back(8'hFF, got);
    checks++; if (got !== 8'h5A) begin failures++; $display("FAIL rst_mem_kept got=%h exp=5a", got); end
  endtask

  initial begin
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    rst_n    = 1'b0;
    test_reset();
    test_write_addr();
    test_write_data();
    test_read_addr();
    test_read_data();
    test_abort();
    test_back_to_back();
    test_reset_keeps_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
